dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 20 ++
 rtl/dmem_arbiter_rr_arb2.sv | 49 ++++
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default geometry and the
// owner encoding used by the round-robin history register.
package dmem_arbiter_pkg;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned MAX_BURST = 4;

    // Which requester was granted most recently.
    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_e;

    // Owner code for a grant pair (only meaningful when one grant is high).
    function automatic owner_e owner_of(input logic host_gnt);
        return host_gnt ? OWN_HOST : OWN_CPU;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter between the CPU and the host ports. Holds the
// last_owner history; the caller reports the grant it actually issued so
// that overrides made outside this block still update the history.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic   clock_i,
    input  logic   reset_ni,
    input  logic   cpu_req_i,
    input  logic   host_req_i,
    input  logic   upd_i,
    input  owner_e upd_owner_i,
    output logic   cpu_gnt_o,
    output logic   host_gnt_o,
    output owner_e last_owner_o
);

    owner_e last_owner_q;

    // Single requester wins outright; on a tie the port not granted last wins.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
        cpu_gnt_o  = 1'b0;
        host_gnt_o = 1'b0;
        if (cpu_req_i && host_req_i) begin
            if (last_owner_q == OWN_HOST) begin
                cpu_gnt_o = 1'b1;
            end else begin
                host_gnt_o = 1'b1;
            end
        end else begin
            cpu_gnt_o  = cpu_req_i;
            host_gnt_o = host_req_i;
        end
    end

    // History register; resets to HOST so the CPU wins the first tie.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            last_owner_q <= OWN_HOST;
        end else if (upd_i) begin
            last_owner_q <= upd_owner_i;
        end
    end

    assign last_owner_o = last_owner_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing one single-port synchronous data memory (1-cycle read
// latency) between a CPU port and a host/debug-loader port. Round-robin on
// ties, with a host lock that may hold the memory for up to MAX_BURST extra
// grants while the CPU is waiting.
module dmem_arbiter #(
    parameter int unsigned ADDR_W    = dmem_arbiter_pkg::ADDR_W,
    parameter int unsigned DATA_W    = dmem_arbiter_pkg::DATA_W,
    parameter int unsigned MAX_BURST = dmem_arbiter_pkg::MAX_BURST
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              enable_i,
    // CPU port
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_stall_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_rvalid_o,
    // Host port
    input  logic              host_req_i,
    input  logic              host_we_i,
    input  logic              host_lock_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_wdata_i,
    output logic              host_gnt_o,
    output logic [DATA_W-1:0] host_rdata_o,
    output logic              host_rvalid_o,
    // Data memory
    output logic [ADDR_W-1:0] d_addr_o,
    output logic [DATA_W-1:0] d_dataout_o,
    output logic              d_we_o,
    input  logic [DATA_W-1:0] d_datain_i
);

    import dmem_arbiter_pkg::*;

    localparam int unsigned         CNT_W       = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]    BURST_LIMIT = CNT_W'(MAX_BURST);

    logic              arb_on;
    logic              rr_cpu_gnt;
    logic              rr_host_gnt;
    owner_e            last_owner;
    logic              lock_active;
    logic              burst_full;
    logic              cpu_gnt;
    logic              host_gnt;

    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              host_gnt_prev_q;
    logic              cpu_rd_pend_q;
    logic              host_rd_pend_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] host_rdata_q;

    // Grants are suppressed while disabled and while reset is held, so the
    // memory sees an idle bus in both cases.
    assign arb_on = enable_i & reset_ni;

    // The host may keep the memory only if it held it last cycle, still asks
    // with lock set, and has not used up its burst allowance.
    assign lock_active = host_lock_i & host_req_i & host_gnt_prev_q &
                         (burst_cnt_q < BURST_LIMIT);
    assign burst_full  = (burst_cnt_q == BURST_LIMIT);

    rr_arb2 u_rr (
        .clock_i      (clock_i),
        .reset_ni     (reset_ni),
        .cpu_req_i    (cpu_req_i),
        .host_req_i   (host_req_i),
        .upd_i        (cpu_gnt | host_gnt),
        .upd_owner_i  (owner_of(host_gnt)),
        .cpu_gnt_o    (rr_cpu_gnt),
        .host_gnt_o   (rr_host_gnt),
        .last_owner_o (last_owner)
    );

    // Final grant: lock overrides round-robin; an exhausted burst hands the
    // memory to a waiting CPU.
    always_comb begin
        cpu_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (arb_on) begin
            if (lock_active) begin
                host_gnt = 1'b1;
            end else if (burst_full && cpu_req_i) begin
                cpu_gnt = 1'b1;
            end else begin
                cpu_gnt  = rr_cpu_gnt;
                host_gnt = rr_host_gnt;
            end
        end
    end

    // Burst counter: counts locked host grants that keep the CPU waiting.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (cpu_gnt || !host_req_i || !host_lock_i) begin
            burst_cnt_d = '0;
        end else if (host_gnt && lock_active && cpu_req_i) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
    end

    // Memory bus driven by whichever port is granted, zero when idle.
    always_comb begin
        d_addr_o    = '0;
        d_dataout_o = '0;
        d_we_o      = 1'b0;
        if (cpu_gnt) begin
            d_addr_o    = cpu_addr_i;
            d_dataout_o = cpu_wdata_i;
            d_we_o      = cpu_we_i;
        end else if (host_gnt) begin
            d_addr_o    = host_addr_i;
            d_dataout_o = host_wdata_i;
            d_we_o      = host_we_i;
        end
    end

    // Arbitration state and read tracking; reset drops any read in flight.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            burst_cnt_q     <= '0;
            host_gnt_prev_q <= 1'b0;
            cpu_rd_pend_q   <= 1'b0;
            host_rd_pend_q  <= 1'b0;
            cpu_rdata_q     <= '0;
            host_rdata_q    <= '0;
        end else begin
            burst_cnt_q     <= burst_cnt_d;
            host_gnt_prev_q <= host_gnt;
            cpu_rd_pend_q   <= cpu_gnt & ~cpu_we_i;
            host_rd_pend_q  <= host_gnt & ~host_we_i;
            if (cpu_rd_pend_q) begin
                cpu_rdata_q <= d_datain_i;
            end
            if (host_rd_pend_q) begin
                host_rdata_q <= d_datain_i;
            end
        end
    end

    // Read data is the memory output in the return cycle, otherwise the
    // last value returned to that port.
    assign cpu_rvalid_o  = cpu_rd_pend_q;
    assign host_rvalid_o = host_rd_pend_q;
    assign cpu_rdata_o   = cpu_rd_pend_q  ? d_datain_i : cpu_rdata_q;
    assign host_rdata_o  = host_rd_pend_q ? d_datain_i : host_rdata_q;

    assign cpu_gnt_o   = cpu_gnt;
    assign host_gnt_o  = host_gnt;
    assign cpu_stall_o = cpu_req_i & ~cpu_gnt;

endmodule
